// File: rtl/mesi_isc_pkg.sv
// Shared encodings for the single-CPU MESI test responder: mbus/cbus commands,
// responder state machine and the stall LFSR constants.
package mesi_isc_pkg;

    typedef enum logic [2:0] {
        MBUS_NOP      = 3'd0,
        MBUS_WR       = 3'd1,
        MBUS_RD       = 3'd2,
        MBUS_WR_BROAD = 3'd3,
        MBUS_RD_BROAD = 3'd4
    } mbus_cmd_e;

    typedef enum logic [2:0] {
        CBUS_NOP   = 3'd0,
        CBUS_EN_WR = 3'd3,
        CBUS_EN_RD = 3'd4
    } cbus_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_EN   = 2'd3
    } resp_state_e;

    // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3.
    localparam logic [7:0] LFSR_SEED = 8'h5A;
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

endpackage

// File: rtl/mesi_isc_tb_lfsr8.sv
// 8-bit Fibonacci LFSR that produces the pseudo-random stall bit used to
// stretch the responder's WAIT phase.
module mesi_isc_tb_lfsr8
    import mesi_isc_pkg::*;
(
    input  logic clk,
    input  logic rst,
    output logic stall
);

    logic [7:0] lfsr_reg;
    logic [7:0] lfsr_next;

    always_comb begin
        lfsr_next = {lfsr_reg[6:0], ^(lfsr_reg & LFSR_TAPS)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end

    assign stall = lfsr_reg[0];

endmodule

// File: rtl/mesi_isc_tb_mem_resp.sv
// Stand-in for the MESI coherency controller plus main memory for one CPU.
// Define MESI_ISC_TB_MEM_RESP_STALL_EN to add LFSR-driven random ack latency.
module mesi_isc_tb_mem_resp
    import mesi_isc_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MBUS_CMD_WIDTH = 3,
    parameter int CBUS_CMD_WIDTH = 3,
    parameter int MEM_AW         = 6,
    parameter int ACK_LAT        = 2
)
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [MBUS_CMD_WIDTH-1:0] mbus_cmd_i,
    input  logic [ADDR_WIDTH-1:0]     mbus_addr_i,
    input  logic [DATA_WIDTH-1:0]     mbus_data_i,
    output logic                      mbus_ack_o,
    output logic [DATA_WIDTH-1:0]     mbus_data_o,
    output logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_o,
    output logic [ADDR_WIDTH-1:0]     cbus_addr_o,
    input  logic                      cbus_ack_i
);

    localparam int         DEPTH    = 1 << MEM_AW;
    localparam logic [3:0] CNT_LOAD = 4'(ACK_LAT - 1);

    localparam logic [MBUS_CMD_WIDTH-1:0] CMD_NOP      = MBUS_CMD_WIDTH'(MBUS_NOP);
    localparam logic [MBUS_CMD_WIDTH-1:0] CMD_WR       = MBUS_CMD_WIDTH'(MBUS_WR);
    localparam logic [MBUS_CMD_WIDTH-1:0] CMD_RD       = MBUS_CMD_WIDTH'(MBUS_RD);
    localparam logic [MBUS_CMD_WIDTH-1:0] CMD_WR_BROAD = MBUS_CMD_WIDTH'(MBUS_WR_BROAD);
    localparam logic [MBUS_CMD_WIDTH-1:0] CMD_RD_BROAD = MBUS_CMD_WIDTH'(MBUS_RD_BROAD);

    resp_state_e               state_reg, state_next;
    logic [3:0]                cnt_reg, cnt_next;
    logic [MBUS_CMD_WIDTH-1:0] cmd_reg, cmd_next;
    logic [ADDR_WIDTH-1:0]     addr_reg, addr_next;
    logic [DATA_WIDTH-1:0]     data_reg, data_next;
    logic [DATA_WIDTH-1:0]     rd_data_reg;
    logic [DATA_WIDTH-1:0]     mem [DEPTH];

    logic              stall;
    logic              is_broad;
    logic              rd_en;
    logic              wr_en;
    logic [MEM_AW-1:0] rd_idx;
    logic [MEM_AW-1:0] wr_idx;

`ifdef MESI_ISC_TB_MEM_RESP_STALL_EN
    mesi_isc_tb_lfsr8 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .stall (stall)
    );
`else
    assign stall = 1'b0;
`endif

    assign is_broad = (cmd_reg == CMD_WR_BROAD) || (cmd_reg == CMD_RD_BROAD);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        cmd_next   = cmd_reg;
        addr_next  = addr_reg;
        data_next  = data_reg;
        case (state_reg)
            ST_IDLE: begin
                if (mbus_cmd_i != CMD_NOP) begin
                    cmd_next   = mbus_cmd_i;
                    addr_next  = mbus_addr_i;
                    data_next  = mbus_data_i;
                    cnt_next   = CNT_LOAD;
                    state_next = (ACK_LAT == 1) ? ST_ACK : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!stall) begin
                    cnt_next = cnt_reg - 4'd1;
                    if (cnt_reg <= 4'd1) begin
                        state_next = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                state_next = is_broad ? ST_EN : ST_IDLE;
            end
            ST_EN: begin
                if (cbus_ack_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            cmd_reg   <= '0;
            addr_reg  <= '0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            cmd_reg   <= cmd_next;
            addr_reg  <= addr_next;
            data_reg  <= data_next;
        end
    end

    // Read on the edge entering ACK so the word is already valid in the ack cycle.
    assign rd_en  = (state_next == ST_ACK) && (state_reg != ST_ACK) && (cmd_next == CMD_RD);
    assign rd_idx = addr_next[MEM_AW+1:2];
    assign wr_en  = (state_reg == ST_ACK) && (cmd_reg == CMD_WR) && !rst;
    assign wr_idx = addr_reg[MEM_AW+1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= data_reg;
        end
    end

    always_comb begin
        mbus_ack_o  = (state_reg == ST_ACK);
        mbus_data_o = rd_data_reg;
        cbus_cmd_o  = CBUS_CMD_WIDTH'(CBUS_NOP);
        cbus_addr_o = '0;
        if (state_reg == ST_EN) begin
            cbus_cmd_o  = (cmd_reg == CMD_WR_BROAD) ? CBUS_CMD_WIDTH'(CBUS_EN_WR)
                                                    : CBUS_CMD_WIDTH'(CBUS_EN_RD);
            cbus_addr_o = addr_reg;
        end
    end

endmodule

// File: tb/tb_mesi_isc_tb_mem_resp.sv
// Directed bench for mesi_isc_tb_mem_resp with ACK_LAT=2, MEM_AW=6: reset,
// RD/WR with wrap, broadcast/enable handshakes, reset aborts and a random RD/WR run.
module tb_mesi_isc_tb_mem_resp;

    localparam int ACK_LAT = 2;

    localparam logic [2:0] C_NOP      = 3'd0;
    localparam logic [2:0] C_WR       = 3'd1;
    localparam logic [2:0] C_RD       = 3'd2;
    localparam logic [2:0] C_WR_BROAD = 3'd3;
    localparam logic [2:0] C_RD_BROAD = 3'd4;
    localparam logic [2:0] EN_WR      = 3'd3;
    localparam logic [2:0] EN_RD      = 3'd4;

    logic        clk;
    logic        rst;
    logic [2:0]  mbus_cmd_i;
    logic [31:0] mbus_addr_i;
    logic [31:0] mbus_data_i;
    logic        mbus_ack_o;
    logic [31:0] mbus_data_o;
    logic [2:0]  cbus_cmd_o;
    logic [31:0] cbus_addr_o;
    logic        cbus_ack_i;

    int vec_count  = 0;
    int miss_count = 0;

    logic [31:0] model_mem [64];

    mesi_isc_tb_mem_resp #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .MBUS_CMD_WIDTH (3),
        .CBUS_CMD_WIDTH (3),
        .MEM_AW         (6),
        .ACK_LAT        (ACK_LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mbus_cmd_i  (mbus_cmd_i),
        .mbus_addr_i (mbus_addr_i),
        .mbus_data_i (mbus_data_i),
        .mbus_ack_o  (mbus_ack_o),
        .mbus_data_o (mbus_data_o),
        .cbus_cmd_o  (cbus_cmd_o),
        .cbus_addr_o (cbus_addr_o),
        .cbus_ack_i  (cbus_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_count++;
        if (got !== exp) begin
            miss_count++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a command in an IDLE cycle and wait for its ack; returns the
    // number of cycles after the sampling edge up to and including the ack cycle.
    task automatic issue(input logic [2:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                         output int lat, output logic [31:0] rdata);
        mbus_cmd_i  = cmd;
        mbus_addr_i = addr;
        mbus_data_i = data;
        step();
        mbus_cmd_i = C_NOP;
        lat = 1;
        while (!mbus_ack_o && lat < 64) begin
            step();
            lat++;
        end
        if (!mbus_ack_o) begin
            check_val("ack_timeout", 64'(mbus_ack_o), 64'd1);
            lat = -1;
        end
        rdata = mbus_data_o;
    endtask

    // Plain RD/WR including the cycle after ack, leaving the DUT in IDLE.
    task automatic rw_op(input string tag, input logic [2:0] cmd, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] exp_rd, input bit chk_rd);
        int lat;
        logic [31:0] rdata;
        issue(cmd, addr, data, lat, rdata);
`ifdef MESI_ISC_TB_MEM_RESP_STALL_EN
        check_val({tag, "_lat_min"}, 64'(lat >= ACK_LAT), 64'd1);
`else
        check_val({tag, "_lat"}, 64'(lat), 64'(ACK_LAT));
`endif
        if (chk_rd) check_val({tag, "_data"}, 64'(rdata), 64'(exp_rd));
        step();
        check_val({tag, "_ack_pulse"}, 64'(mbus_ack_o), 64'd0);
    endtask

    initial begin
        int lat;
        int acks;
        int en_busy;
        logic [31:0] rdata;
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  c;

        rst         = 1'b1;
        mbus_cmd_i  = C_NOP;
        mbus_addr_i = '0;
        mbus_data_i = '0;
        cbus_ack_i  = 1'b0;
        repeat (3) step();

        check_val("rst_ack", 64'(mbus_ack_o), 64'd0);
        check_val("rst_data", 64'(mbus_data_o), 64'd0);
        check_val("rst_cbus_cmd", 64'(cbus_cmd_o), 64'(C_NOP));
        check_val("rst_cbus_addr", 64'(cbus_addr_o), 64'd0);
        rst = 1'b0;

        acks = 0;
        en_busy = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (mbus_ack_o) acks++;
            if (cbus_cmd_o != C_NOP) en_busy++;
        end
        check_val("nop_acks", 64'(acks), 64'd0);
        check_val("nop_cbus", 64'(en_busy), 64'd0);

        // Basic write / read / wrapped read, then read data must hold across a WR.
        rw_op("wr10", C_WR, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        rw_op("rd10", C_RD, 32'h10, 32'h0, 32'hDEADBEEF, 1'b1);
        rw_op("rd110", C_RD, 32'h110, 32'h0, 32'hDEADBEEF, 1'b1);
        rw_op("wr14", C_WR, 32'h14, 32'h12345678, 32'h0, 1'b0);
        check_val("rd_hold", 64'(mbus_data_o), 64'hDEADBEEF);
        rw_op("rd14", C_RD, 32'h14, 32'h0, 32'h12345678, 1'b1);
        rw_op("cmd7", 3'd7, 32'h14, 32'hFFFFFFFF, 32'h0, 1'b0);
        check_val("cmd7_cbus", 64'(cbus_cmd_o), 64'(C_NOP));
        rw_op("rd14b", C_RD, 32'h14, 32'h0, 32'h12345678, 1'b1);

        // RD_BROAD with the cbus ack arriving in the third EN cycle.
        issue(C_RD_BROAD, 32'h40, 32'h0, lat, rdata);
        check_val("rdb_lat", 64'(lat), 64'(ACK_LAT));
        for (int i = 1; i <= 3; i++) begin
            step();
            check_val($sformatf("rdb_en%0d_cmd", i), 64'(cbus_cmd_o), 64'(EN_RD));
            check_val($sformatf("rdb_en%0d_addr", i), 64'(cbus_addr_o), 64'h40);
            check_val($sformatf("rdb_en%0d_ack", i), 64'(mbus_ack_o), 64'd0);
        end
        cbus_ack_i = 1'b1;
        step();
        cbus_ack_i = 1'b0;
        check_val("rdb_done_cmd", 64'(cbus_cmd_o), 64'(C_NOP));

        // WR_BROAD presented while the previous EN is still waiting.
        issue(C_RD_BROAD, 32'h80, 32'h0, lat, rdata);
        step();
        check_val("wrb_prev_en", 64'(cbus_cmd_o), 64'(EN_RD));
        mbus_cmd_i  = C_WR_BROAD;
        mbus_addr_i = 32'h84;
        acks = 0;
        if (mbus_ack_o) acks++;
        step();
        if (mbus_ack_o) acks++;
        cbus_ack_i = 1'b1;
        step();
        cbus_ack_i = 1'b0;
        if (mbus_ack_o) acks++;
        check_val("wrb_no_early_ack", 64'(acks), 64'd0);
        check_val("wrb_idle_cbus", 64'(cbus_cmd_o), 64'(C_NOP));
        step();
        mbus_cmd_i = C_NOP;
        check_val("wrb_wait_ack", 64'(mbus_ack_o), 64'd0);
        step();
        check_val("wrb_ack", 64'(mbus_ack_o), 64'd1);
        step();
        check_val("wrb_en_cmd", 64'(cbus_cmd_o), 64'(EN_WR));
        check_val("wrb_en_addr", 64'(cbus_addr_o), 64'h84);
        cbus_ack_i = 1'b1;
        step();
        cbus_ack_i = 1'b0;
        check_val("wrb_done_cmd", 64'(cbus_cmd_o), 64'(C_NOP));

        // Reset during WAIT drops the pending write.
        rw_op("wr20_old", C_WR, 32'h20, 32'hCAFE0020, 32'h0, 1'b0);
        mbus_cmd_i  = C_WR;
        mbus_addr_i = 32'h20;
        mbus_data_i = 32'h1;
        step();
        mbus_cmd_i = C_NOP;
        rst = 1'b1;
        step();
        rst = 1'b0;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (mbus_ack_o) acks++;
        end
        check_val("rstwait_acks", 64'(acks), 64'd0);
        rw_op("rd20", C_RD, 32'h20, 32'h0, 32'hCAFE0020, 1'b1);

        // Reset coinciding with the WR ack cycle suppresses the write.
        rw_op("wr24_old", C_WR, 32'h24, 32'h77, 32'h0, 1'b0);
        issue(C_WR, 32'h24, 32'h55, lat, rdata);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("rstack_ack", 64'(mbus_ack_o), 64'd0);
        check_val("rstack_data", 64'(mbus_data_o), 64'd0);
        rw_op("rd24", C_RD, 32'h24, 32'h0, 32'h77, 1'b1);

        // Fill memory, then random RD/WR against the reference model.
        for (int i = 0; i < 64; i++) begin
            d = 32'hA5000000 + 32'(i * 7);
            model_mem[i] = d;
            rw_op($sformatf("fill%0d", i), C_WR, 32'(i << 2), d, 32'h0, 1'b0);
        end
        for (int i = 0; i < 200; i++) begin
            a = $urandom;
            d = $urandom;
            c = ($urandom_range(0, 1) == 0) ? C_WR : C_RD;
            if (c == C_WR) begin
                rw_op($sformatf("rnd%0d_wr", i), C_WR, a, d, 32'h0, 1'b0);
                model_mem[a[7:2]] = d;
            end else begin
                rw_op($sformatf("rnd%0d_rd", i), C_RD, a, 32'h0, model_mem[a[7:2]], 1'b1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
